// File: rtl/adc_sample_buffer.sv
// adc_sample_buffer: circular FIFO capturing vco_adc samples, with a host
// request/valid read port, fill level, sticky overflow and saturating drop count.
module adc_sample_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH_LOG2 = 4,
    parameter int DROP_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable_in,
    input  logic                  clear_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_valid_in,
    input  logic                  rd_en_in,
    output logic [DATA_WIDTH-1:0] rd_data_out,
    output logic                  rd_valid_out,
    output logic [DEPTH_LOG2:0]   count_out,
    output logic                  empty_out,
    output logic                  full_out,
    output logic                  overflow_out,
    output logic [DROP_WIDTH-1:0] drop_count_out
);

    localparam int                  DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0] CNT_ONE   = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
    localparam logic [DROP_WIDTH-1:0] DROP_ONE = {{(DROP_WIDTH-1){1'b0}}, 1'b1};

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [DEPTH_LOG2-1:0] wptr_q, wptr_d;
    logic [DEPTH_LOG2-1:0] rptr_q, rptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  overflow_q, overflow_d;
    logic [DROP_WIDTH-1:0] drop_cnt_q, drop_cnt_d;

    logic empty, full;
    logic strobe, rd_acc, wr_acc, drop;

    assign empty = (count_q == '0);
    assign full  = (count_q == DEPTH_CNT);

    // Handshake decode; clear suppresses every action in its cycle.
    always_comb begin
        strobe = data_valid_in & enable_in & ~clear_in;
        rd_acc = rd_en_in & ~empty & ~clear_in;
        wr_acc = strobe & (~full | rd_acc);
        drop   = strobe & full & ~rd_acc;
    end

    // Next-state for pointers, level, read port and drop status.
    always_comb begin
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        count_d    = count_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        if (clear_in) begin
            wptr_d     = '0;
            rptr_d     = '0;
            count_d    = '0;
            overflow_d = 1'b0;
            drop_cnt_d = '0;
        end else begin
            if (wr_acc) wptr_d = wptr_q + PTR_ONE;
            if (rd_acc) begin
                rptr_d     = rptr_q + PTR_ONE;
                rd_data_d  = mem[rptr_q];
                rd_valid_d = 1'b1;
            end
            if (wr_acc && !rd_acc) count_d = count_q + CNT_ONE;
            else if (rd_acc && !wr_acc) count_d = count_q - CNT_ONE;
            if (drop) begin
                overflow_d = 1'b1;
                if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + DROP_ONE;
            end
        end
    end

    // State registers; reset overrides clear and any in-flight read.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Sample storage; contents are don't-care after reset so no reset here.
    always_ff @(posedge clk) begin
        if (!rst && wr_acc) mem[wptr_q] <= data_in;
    end

    assign rd_data_out    = rd_data_q;
    assign rd_valid_out   = rd_valid_q;
    assign count_out      = count_q;
    assign empty_out      = empty;
    assign full_out       = full;
    assign overflow_out   = overflow_q;
    assign drop_count_out = drop_cnt_q;

endmodule

// File: tb/tb_adc_sample_buffer.sv
// Directed bench for adc_sample_buffer (DROP_WIDTH=2 so saturation is reachable).
module tb_adc_sample_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable_in = 1'b1;
    logic        clear_in = 1'b0;
    logic [31:0] data_in = '0;
    logic        data_valid_in = 1'b0;
    logic        rd_en_in = 1'b0;
    logic [31:0] rd_data_out;
    logic        rd_valid_out;
    logic [4:0]  count_out;
    logic        empty_out;
    logic        full_out;
    logic        overflow_out;
    logic [1:0]  drop_count_out;

    int n_checks = 0;
    int n_fail   = 0;

    adc_sample_buffer #(.DATA_WIDTH(32), .DEPTH_LOG2(4), .DROP_WIDTH(2)) dut (
        .clk(clk), .rst(rst), .enable_in(enable_in), .clear_in(clear_in),
        .data_in(data_in), .data_valid_in(data_valid_in), .rd_en_in(rd_en_in),
        .rd_data_out(rd_data_out), .rd_valid_out(rd_valid_out), .count_out(count_out),
        .empty_out(empty_out), .full_out(full_out), .overflow_out(overflow_out),
        .drop_count_out(drop_count_out)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One clock: drive at negedge, return at the next negedge with outputs settled.
    task automatic step(input logic v, input logic [31:0] d, input logic r);
        data_valid_in = v; data_in = d; rd_en_in = r;
        @(negedge clk);
        data_valid_in = 1'b0; rd_en_in = 1'b0;
    endtask

    task automatic do_clear();
        clear_in = 1'b1; step(0, 0, 0); clear_in = 1'b0;
    endtask

    task automatic fill(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) step(1, base + i, 0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step(0, 0, 0);
        rst = 1'b0;
        step(0, 0, 0);
        n_checks++; if (count_out !== 5'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", count_out); end
        n_checks++; if (empty_out !== 1'b1) begin n_fail++; $display("FAIL reset_empty got %b exp 1", empty_out); end
        n_checks++; if (full_out !== 1'b0) begin n_fail++; $display("FAIL reset_full got %b exp 0", full_out); end
        n_checks++; if (rd_valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid got %b exp 0", rd_valid_out); end
        n_checks++; if (overflow_out !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got %b exp 0", overflow_out); end
        n_checks++; if (drop_count_out !== 2'd0) begin n_fail++; $display("FAIL reset_drop got %0d exp 0", drop_count_out); end
        n_checks++; if (rd_data_out !== 32'd0) begin n_fail++; $display("FAIL reset_rd_data got %h exp 0", rd_data_out); end
    endtask

    task automatic test_fill_drain();
        do_clear();
        fill(32'h1, 16);
        n_checks++; if (full_out !== 1'b1) begin n_fail++; $display("FAIL fd_full got %b exp 1", full_out); end
        n_checks++; if (count_out !== 5'd16) begin n_fail++; $display("FAIL fd_count got %0d exp 16", count_out); end
        for (int i = 0; i < 16; i++) begin
            step(0, 0, 1);
            n_checks++; if (rd_valid_out !== 1'b1 || rd_data_out !== 32'(i + 1))
                begin n_fail++; $display("FAIL fd_read%0d got v=%b d=%h exp v=1 d=%h", i, rd_valid_out, rd_data_out, i + 1); end
        end
        n_checks++; if (empty_out !== 1'b1) begin n_fail++; $display("FAIL fd_empty got %b exp 1", empty_out); end
        // read while empty: ignored, data held
        step(0, 0, 1);
        n_checks++; if (rd_valid_out !== 1'b0 || rd_data_out !== 32'h10 || count_out !== 5'd0)
            begin n_fail++; $display("FAIL empty_read got v=%b d=%h c=%0d exp v=0 d=10 c=0", rd_valid_out, rd_data_out, count_out); end
    endtask

    task automatic test_overflow();
        do_clear();
        fill(32'h1, 16);
        for (int k = 0; k < 3; k++) begin
            step(1, 32'hDEAD_0000 + k, 0);
            n_checks++; if (drop_count_out !== 2'(k + 1) || overflow_out !== 1'b1)
                begin n_fail++; $display("FAIL ovf_drop%0d got dc=%0d ov=%b exp dc=%0d ov=1", k, drop_count_out, overflow_out, k + 1); end
        end
        n_checks++; if (count_out !== 5'd16) begin n_fail++; $display("FAIL ovf_count got %0d exp 16", count_out); end
        for (int i = 0; i < 16; i++) begin
            step(0, 0, 1);
            n_checks++; if (rd_valid_out !== 1'b1 || rd_data_out !== 32'(i + 1))
                begin n_fail++; $display("FAIL ovf_read%0d got v=%b d=%h exp d=%h", i, rd_valid_out, rd_data_out, i + 1); end
        end
        n_checks++; if (empty_out !== 1'b1 || overflow_out !== 1'b1)
            begin n_fail++; $display("FAIL ovf_after got empty=%b ov=%b exp 1 1", empty_out, overflow_out); end
    endtask

    task automatic test_simultaneous();
        do_clear();
        fill(32'h100, 16);
        step(1, 32'hAAAA_5555, 1);
        n_checks++; if (rd_valid_out !== 1'b1 || rd_data_out !== 32'h100 || count_out !== 5'd16 || drop_count_out !== 2'd0 || overflow_out !== 1'b0)
            begin n_fail++; $display("FAIL sim_full got v=%b d=%h c=%0d dc=%0d ov=%b exp 1 100 16 0 0", rd_valid_out, rd_data_out, count_out, drop_count_out, overflow_out); end
        for (int i = 1; i < 16; i++) begin
            step(0, 0, 1);
            n_checks++; if (rd_data_out !== 32'h100 + i) begin n_fail++; $display("FAIL sim_read%0d got %h exp %h", i, rd_data_out, 32'h100 + i); end
        end
        step(0, 0, 1);
        n_checks++; if (rd_valid_out !== 1'b1 || rd_data_out !== 32'hAAAA_5555)
            begin n_fail++; $display("FAIL sim_last got v=%b d=%h exp 1 aaaa5555", rd_valid_out, rd_data_out); end
        n_checks++; if (empty_out !== 1'b1) begin n_fail++; $display("FAIL sim_empty got %b exp 1", empty_out); end
        step(1, 32'h1234, 1);
        n_checks++; if (rd_valid_out !== 1'b0 || count_out !== 5'd1)
            begin n_fail++; $display("FAIL sim_empty_wr got v=%b c=%0d exp 0 1", rd_valid_out, count_out); end
        step(0, 0, 1);
        n_checks++; if (rd_valid_out !== 1'b1 || rd_data_out !== 32'h1234 || count_out !== 5'd0)
            begin n_fail++; $display("FAIL sim_empty_rd got v=%b d=%h c=%0d exp 1 1234 0", rd_valid_out, rd_data_out, count_out); end
    endtask

    task automatic test_clear_enable();
        do_clear();
        fill(32'h200, 17);              // 16 stored, 1 dropped
        for (int i = 0; i < 11; i++) step(0, 0, 1);
        n_checks++; if (count_out !== 5'd5 || overflow_out !== 1'b1 || rd_data_out !== 32'h20A)
            begin n_fail++; $display("FAIL clr_pre got c=%0d ov=%b d=%h exp 5 1 20a", count_out, overflow_out, rd_data_out); end
        clear_in = 1'b1; step(1, 32'h5555, 1); clear_in = 1'b0;
        n_checks++; if (count_out !== 5'd0 || overflow_out !== 1'b0 || drop_count_out !== 2'd0 || rd_valid_out !== 1'b0)
            begin n_fail++; $display("FAIL clr_state got c=%0d ov=%b dc=%0d v=%b exp 0 0 0 0", count_out, overflow_out, drop_count_out, rd_valid_out); end
        n_checks++; if (rd_data_out !== 32'h20A) begin n_fail++; $display("FAIL clr_hold got %h exp 20a", rd_data_out); end
        step(0, 0, 1);
        n_checks++; if (rd_valid_out !== 1'b0 || empty_out !== 1'b1)
            begin n_fail++; $display("FAIL clr_nothing got v=%b e=%b exp 0 1", rd_valid_out, empty_out); end
        enable_in = 1'b0;
        for (int i = 0; i < 4; i++) step(1, 32'h300 + i, 0);
        n_checks++; if (count_out !== 5'd0 || drop_count_out !== 2'd0 || overflow_out !== 1'b0)
            begin n_fail++; $display("FAIL dis_ignore got c=%0d dc=%0d ov=%b exp 0 0 0", count_out, drop_count_out, overflow_out); end
        enable_in = 1'b1;
        fill(32'h400, 16);
        enable_in = 1'b0;
        step(1, 32'h999, 1);            // read works; full strobe ignored, no drop
        n_checks++; if (rd_valid_out !== 1'b1 || rd_data_out !== 32'h400 || count_out !== 5'd15 || drop_count_out !== 2'd0)
            begin n_fail++; $display("FAIL dis_read got v=%b d=%h c=%0d dc=%0d exp 1 400 15 0", rd_valid_out, rd_data_out, count_out, drop_count_out); end
        enable_in = 1'b1;
    endtask

    task automatic test_wrap_saturate();
        do_clear();
        for (int i = 0; i <= 40; i++) begin
            step(i < 40, 32'h1000 + i, i > 0);
            if (i > 0) begin
                n_checks++; if (rd_valid_out !== 1'b1 || rd_data_out !== 32'h1000 + i - 1)
                    begin n_fail++; $display("FAIL wrap%0d got v=%b d=%h exp 1 %h", i, rd_valid_out, rd_data_out, 32'h1000 + i - 1); end
            end
        end
        n_checks++; if (count_out !== 5'd0) begin n_fail++; $display("FAIL wrap_count got %0d exp 0", count_out); end
        fill(32'h2000, 21);             // 16 stored, 5 dropped
        n_checks++; if (drop_count_out !== 2'd3 || overflow_out !== 1'b1 || count_out !== 5'd16)
            begin n_fail++; $display("FAIL sat got dc=%0d ov=%b c=%0d exp 3 1 16", drop_count_out, overflow_out, count_out); end
        step(0, 0, 1);
        n_checks++; if (rd_data_out !== 32'h2000) begin n_fail++; $display("FAIL sat_read got %h exp 2000", rd_data_out); end
    endtask

    task automatic test_reset_mid();
        do_clear();
        fill(32'h3000, 3);
        rst = 1'b1; step(1, 32'h3333, 1); rst = 1'b0;
        n_checks++; if (rd_valid_out !== 1'b0 || count_out !== 5'd0 || empty_out !== 1'b1 || rd_data_out !== 32'd0)
            begin n_fail++; $display("FAIL rst_mid got v=%b c=%0d e=%b d=%h exp 0 0 1 0", rd_valid_out, count_out, empty_out, rd_data_out); end
        step(0, 0, 1);
        n_checks++; if (rd_valid_out !== 1'b0) begin n_fail++; $display("FAIL rst_mid_rd got %b exp 0", rd_valid_out); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_fill_drain();
        test_overflow();
        test_simultaneous();
        test_clear_enable();
        test_wrap_saturate();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/adc_sample_buffer.md
Name: adc_sample_buffer

Overview:
Receive-side consumer of the VCO ADC output stream. Captures each sinc-filtered sample presented on `data_out`/`data_valid_out` of `vco_adc` into a circular FIFO. A host-side reader pops samples with a request/valid handshake. Reports fill level, an overflow flag and a count of dropped samples, so that the host or test logic can drain the ADC without losing track of discarded data.

Parameters:
- DATA_WIDTH, 32, sample width; matches `vco_adc` `data_out`.
- DEPTH_LOG2, 4, log2 of FIFO depth (default 16 entries).
- DROP_WIDTH, 16, width of the saturating dropped-sample counter.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- enable_in  input  1  capture enable; when low, incoming samples are ignored and not counted as drops.
- clear_in  input  1  synchronous flush of FIFO contents and status.
- data_in  input  DATA_WIDTH  sample from `vco_adc` `data_out`.
- data_valid_in  input  1  one-cycle strobe from `vco_adc` `data_valid_out`.
- rd_en_in  input  1  host pop request, one sample per asserted cycle.
- rd_data_out  output  DATA_WIDTH  popped sample.
- rd_valid_out  output  1  one-cycle strobe marking `rd_data_out` valid.
- count_out  output  DEPTH_LOG2+1  current number of stored samples.
- empty_out  output  1  high when count_out==0.
- full_out  output  1  high when count_out==2^DEPTH_LOG2.
- overflow_out  output  1  sticky; set on the first dropped sample.
- drop_count_out  output  DROP_WIDTH  number of dropped samples; saturates at all-ones.

Behaviour:
- Reset (`rst`=1 at posedge clk):
  - Pointers, `count_out`, `rd_data_out`, `rd_valid_out`, `overflow_out` and `drop_count_out` all go to 0.
  - `empty_out`=1, `full_out`=0.
  - Memory contents are don't-care.
- Storage: 2^DEPTH_LOG2 entries, DEPTH_LOG2-bit write and read pointers that wrap modulo depth. `count_out` is held as an explicit register.
- Write accept: `wr_acc` = `data_valid_in` & `enable_in` & (!`full_out` | `rd_acc`).
  - The sample is written at wptr and wptr increments.
  - Writing while full is allowed only when the same cycle also pops.
- Drop: `data_valid_in` & `enable_in` & `full_out` & !`rd_acc`.
  - The sample is discarded.
  - `overflow_out` is set to 1 and stays set until reset or clear.
  - `drop_count_out` increments by 1 and holds at 2^DROP_WIDTH-1.
- Read accept: `rd_acc` = `rd_en_in` & !`empty_out`.
  - Memory at rptr is registered into `rd_data_out` and rptr increments.
  - `rd_valid_out`=1 in the following cycle, i.e. latency 1 clock from `rd_en_in` to data.
  - `rd_valid_out` is 0 in every cycle not following an accepted read.
  - `rd_data_out` holds its last value when no read occurs.
- Read when empty: ignored. No underflow state, `rd_valid_out` stays 0, and pointers do not move.
- Simultaneous events:
  - Write and read on the same cycle, non-empty and not full: `count_out` is unchanged and both pointers advance.
  - Full with write and read on the same cycle: both are accepted, `count_out` stays at depth, no drop.
  - Empty with write and read on the same cycle: only the write is accepted, `count_out` becomes 1. There is no fall-through; the new sample is readable from the next cycle.
- Count update: `count_out` next = `count_out` + `wr_acc` - `rd_acc`.
  - `empty_out`/`full_out` are decoded from `count_out` and are valid in the same cycle as `count_out`.
- Clear (`clear_in`=1): behaves as reset for pointers, `count_out`, `overflow_out`, `drop_count_out` and `rd_valid_out`.
  - Clear has priority over a write or read in the same cycle; those are neither stored nor returned.
  - `rd_data_out` retains its value.
- Reset mid-operation: `rst` overrides everything, including `clear_in`.
  - Any read in flight is lost, and `rd_valid_out` is 0 in the cycle after reset.
- `enable_in` low: FIFO reads continue normally. Incoming strobes are ignored and do not touch the overflow or drop status.

Test Plan:
- Reset then idle: `rst` high 3 cycles, release → `count_out`=0, `empty_out`=1, `full_out`=0, `rd_valid_out`=0, `overflow_out`=0, `drop_count_out`=0.
- Fill and drain: `enable_in`=1, write 16 strobes with data 0x0000_0001..0x0000_0010 → `full_out`=1, `count_out`=16. Then 16 back-to-back `rd_en_in` → `rd_valid_out` high 16 consecutive cycles, data 0x01..0x10 in order, then `empty_out`=1.
- Overflow: fill 16, then 3 more strobes with no reads → `overflow_out`=1, `drop_count_out`=3, `count_out`=16. The FIFO still reads out 0x01..0x10 and none of the dropped values.
- Simultaneous at boundaries:
  - Full plus write 0xAAAA_5555 and read in the same cycle → no drop, `count_out`=16, and 0xAAAA_5555 is read last.
  - Empty plus write 0x1234 and read in the same cycle → `rd_valid_out`=0 next cycle, `count_out`=1.
- Clear and enable: with 5 stored samples and `overflow_out`=1, pulse `clear_in` together with a strobe → `count_out`=0, `overflow_out`=0, `drop_count_out`=0, nothing stored. Then with `enable_in`=0, 4 strobes → `count_out` stays 0 and `drop_count_out`=0.
- Pointer wrap and saturation: with DROP_WIDTH=2, stream 40 samples while reading each one 1 cycle later → all 40 are returned in order across pointer wrap. Then drop 5 samples while full → `drop_count_out`=3 (saturated).
